// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - MIPS 5-stage hazard, branch/jump and forwarding control (optional HAZ_PERF_CNT_EN counters)
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic             ID_IsBranch,
    input  logic             ID_BranchNe,
    input  logic             ID_IsJump,
    input  logic             equalR,
    input  logic [4:0]       ID_EX_Rs,
    input  logic [4:0]       ID_EX_Rt,
    input  logic [4:0]       ID_EX_Dest,
    input  logic             ID_EX_MemRead,
    input  logic             ID_EX_RegWrite,
    input  logic [4:0]       EX_MEM_Rd,
    input  logic             EX_MEM_RegWrite,
    input  logic [4:0]       MEM_WB_Rd,
    input  logic             MEM_WB_RegWrite,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_Bubble,
    output logic             IF_Flush,
    output logic             PCSrc,
    output logic             InstSrc,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {RUN, STALL} state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       idex_hit, exmem_hit, memwb_hit, load_use, br_taken;
    logic [2:0] branch_n, hazard_n;

    function automatic logic prod_hit(input logic rw, input logic [4:0] dst,
                                      input logic [4:0] src, input logic use_src);
        return rw && (dst != 5'd0) && use_src && (dst == src);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (prod_hit(EX_MEM_RegWrite, EX_MEM_Rd, src, 1'b1))
            return 2'b01;
        else if (prod_hit(MEM_WB_RegWrite, MEM_WB_Rd, src, 1'b1))
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign ForwardA = fwd_sel(ID_EX_Rs);
    assign ForwardB = fwd_sel(ID_EX_Rt);

    assign idex_hit  = prod_hit(ID_EX_RegWrite, ID_EX_Dest, ID_Rs, ID_UsesRs) ||
                       prod_hit(ID_EX_RegWrite, ID_EX_Dest, ID_Rt, ID_UsesRt);
    assign exmem_hit = prod_hit(EX_MEM_RegWrite, EX_MEM_Rd, ID_Rs, ID_UsesRs) ||
                       prod_hit(EX_MEM_RegWrite, EX_MEM_Rd, ID_Rt, ID_UsesRt);
    assign memwb_hit = prod_hit(MEM_WB_RegWrite, MEM_WB_Rd, ID_Rs, ID_UsesRs) ||
                       prod_hit(MEM_WB_RegWrite, MEM_WB_Rd, ID_Rt, ID_UsesRt);

    // Youngest matching stage sets the stall length: the branch must wait for the regfile write.
    assign branch_n = idex_hit  ? 3'd3 :
                      exmem_hit ? 3'd2 :
                      memwb_hit ? 3'd1 : 3'd0;
    assign load_use = !ID_IsBranch && ID_EX_MemRead && idex_hit;
    assign hazard_n = ID_IsBranch ? branch_n : (load_use ? 3'd1 : 3'd0);
    assign br_taken = ID_IsBranch && (ID_BranchNe ? !equalR : equalR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The detection cycle is the first stall cycle, so STALL covers the remaining N-1.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        ID_Bubble   = 1'b0;
        IF_Flush    = 1'b0;
        PCSrc       = 1'b0;
        InstSrc     = 1'b0;
        case (state_q)
            RUN: begin
                if (hazard_n != 3'd0) begin
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_Bubble   = 1'b1;
                    cnt_d       = hazard_n - 3'd1;
                    state_d     = (hazard_n > 3'd1) ? STALL : RUN;
                end else if (ID_IsBranch) begin
                    PCSrc    = br_taken;
                    IF_Flush = br_taken;
                end else if (ID_IsJump) begin
                    InstSrc = 1'b1;
                end
            end
            STALL: begin
                PCWrite     = 1'b0;
                IF_ID_Write = 1'b0;
                ID_Bubble   = 1'b1;
                if (cnt_q <= 3'd1) begin
                    cnt_d   = 3'd0;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 3'd0;
            end
        endcase
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (ID_Bubble) stall_q <= stall_q + 1'b1;
            if (IF_Flush)  flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with directed vectors
module tb_hazard_ctrl;
    localparam int CNT_W = 32;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] ID_Rs, ID_Rt, ID_EX_Rs, ID_EX_Rt, ID_EX_Dest, EX_MEM_Rd, MEM_WB_Rd;
    logic ID_UsesRs, ID_UsesRt, ID_IsBranch, ID_BranchNe, ID_IsJump, equalR;
    logic ID_EX_MemRead, ID_EX_RegWrite, EX_MEM_RegWrite, MEM_WB_RegWrite;
    logic PCWrite, IF_ID_Write, ID_Bubble, IF_Flush, PCSrc, InstSrc;
    logic [1:0] ForwardA, ForwardB;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
        .ID_IsBranch(ID_IsBranch), .ID_BranchNe(ID_BranchNe), .ID_IsJump(ID_IsJump),
        .equalR(equalR), .ID_EX_Rs(ID_EX_Rs), .ID_EX_Rt(ID_EX_Rt), .ID_EX_Dest(ID_EX_Dest),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_RegWrite(ID_EX_RegWrite),
        .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .MEM_WB_Rd(MEM_WB_Rd), .MEM_WB_RegWrite(MEM_WB_RegWrite),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_Bubble(ID_Bubble),
        .IF_Flush(IF_Flush), .PCSrc(PCSrc), .InstSrc(InstSrc),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string            name;
        logic [9:0]       ctl;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] fc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [CNT_W-1:0] sc_m = '0;
    logic [CNT_W-1:0] fc_m = '0;

    task automatic clr();
        ID_Rs = 0; ID_Rt = 0; ID_UsesRs = 0; ID_UsesRt = 0;
        ID_IsBranch = 0; ID_BranchNe = 0; ID_IsJump = 0; equalR = 0;
        ID_EX_Rs = 0; ID_EX_Rt = 0; ID_EX_Dest = 0; ID_EX_MemRead = 0; ID_EX_RegWrite = 0;
        EX_MEM_Rd = 0; EX_MEM_RegWrite = 0; MEM_WB_Rd = 0; MEM_WB_RegWrite = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        clr();
    endtask

    // ctl = {PCWrite, IF_ID_Write, ID_Bubble, IF_Flush, PCSrc, InstSrc, ForwardA, ForwardB}
    task automatic push(input string name, input logic [9:0] ctl);
        exp_t e;
        e.name = name;
        e.ctl  = ctl;
`ifdef HAZ_PERF_CNT_EN
        e.sc = sc_m;
        e.fc = fc_m;
        if (rst) begin
            sc_m = '0;
            fc_m = '0;
        end else begin
            sc_m = sc_m + CNT_W'(ctl[7]);
            fc_m = fc_m + CNT_W'(ctl[6]);
        end
`else
        e.sc = '0;
        e.fc = '0;
`endif
        q.push_back(e);
    endtask

    task automatic exp_run(input string name, input logic fl, input logic ps,
                           input logic is, input logic [1:0] fa, input logic [1:0] fb);
        push(name, {3'b110, fl, ps, is, fa, fb});
    endtask

    task automatic exp_stall(input string name);
        push(name, {3'b001, 3'b000, 4'b0000});
    endtask

    initial begin : monitor
        exp_t e;
        logic [9:0] act;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e   = q.pop_front();
                act = {PCWrite, IF_ID_Write, ID_Bubble, IF_Flush, PCSrc, InstSrc, ForwardA, ForwardB};
                n_checks++;
                if (act !== e.ctl || stall_cycles !== e.sc || flush_count !== e.fc) begin
                    n_fail++;
                    $display("FAIL %s: got ctl=%b sc=%0d fc=%0d, expected ctl=%b sc=%0d fc=%0d",
                             e.name, act, stall_cycles, flush_count, e.ctl, e.sc, e.fc);
                end
            end
        end
    end

    initial begin : stim
        rst = 1'b1;
        clr();
        repeat (2) @(posedge clk);
        #1;
        exp_run("reset", 0, 0, 0, 2'b00, 2'b00);

        next(); rst = 1'b0;
        exp_run("idle", 0, 0, 0, 2'b00, 2'b00);

        next(); ID_Rs = 2; ID_UsesRs = 1; ID_EX_MemRead = 1; ID_EX_RegWrite = 1; ID_EX_Dest = 2;
        exp_stall("lu_stall");
        next();
        exp_run("lu_after", 0, 0, 0, 2'b00, 2'b00);

        next(); EX_MEM_Rd = 5; EX_MEM_RegWrite = 1; MEM_WB_Rd = 5; MEM_WB_RegWrite = 1;
        ID_EX_Rs = 5; ID_EX_Rt = 5;
        exp_run("fwd_exmem", 0, 0, 0, 2'b01, 2'b01);
        next(); EX_MEM_Rd = 0; EX_MEM_RegWrite = 1; MEM_WB_Rd = 5; MEM_WB_RegWrite = 1;
        ID_EX_Rs = 5; ID_EX_Rt = 5;
        exp_run("fwd_memwb", 0, 0, 0, 2'b10, 2'b10);
        next(); EX_MEM_Rd = 4; EX_MEM_RegWrite = 1; MEM_WB_Rd = 6; MEM_WB_RegWrite = 1;
        ID_EX_Rs = 4; ID_EX_Rt = 6;
        exp_run("fwd_mixed", 0, 0, 0, 2'b01, 2'b10);
        next(); EX_MEM_Rd = 5; ID_EX_Rs = 5; ID_EX_Rt = 5;
        exp_run("fwd_norw", 0, 0, 0, 2'b00, 2'b00);

        for (int i = 1; i <= 3; i++) begin
            next(); ID_IsBranch = 1; ID_Rs = 3; ID_UsesRs = 1; ID_Rt = 9; ID_UsesRt = 1;
            ID_EX_Dest = 3; ID_EX_RegWrite = 1; equalR = 1;
            exp_stall($sformatf("br_stall%0d", i));
        end
        next(); ID_IsBranch = 1; ID_Rs = 3; ID_UsesRs = 1; ID_Rt = 9; ID_UsesRt = 1; equalR = 1;
        exp_run("br_taken", 1, 1, 0, 2'b00, 2'b00);
        next();
        exp_run("br_after", 0, 0, 0, 2'b00, 2'b00);

        next(); ID_IsBranch = 1; ID_BranchNe = 1; ID_Rt = 7; ID_UsesRt = 1; equalR = 1;
        MEM_WB_Rd = 7; MEM_WB_RegWrite = 1;
        exp_stall("bne_stall");
        next(); ID_IsBranch = 1; ID_BranchNe = 1; ID_Rt = 7; ID_UsesRt = 1; equalR = 1;
        exp_run("bne_nottaken", 0, 0, 0, 2'b00, 2'b00);
        next(); ID_IsBranch = 1; ID_BranchNe = 1; ID_Rt = 7; ID_UsesRt = 1; equalR = 0;
        exp_run("bne_taken", 1, 1, 0, 2'b00, 2'b00);

        for (int i = 1; i <= 2; i++) begin
            next(); ID_IsBranch = 1; ID_Rs = 8; ID_UsesRs = 1;
            EX_MEM_Rd = 8; EX_MEM_RegWrite = 1; MEM_WB_Rd = 8; MEM_WB_RegWrite = 1;
            exp_stall($sformatf("br2_s%0d", i));
        end
        next();
        exp_run("br2_done", 0, 0, 0, 2'b00, 2'b00);

        next(); ID_IsJump = 1;
        exp_run("jump", 0, 0, 1, 2'b00, 2'b00);
        next(); ID_IsJump = 1; ID_IsBranch = 1; equalR = 0;
        exp_run("jmp_br", 0, 0, 0, 2'b00, 2'b00);
        next(); ID_Rs = 0; ID_UsesRs = 1; ID_EX_Dest = 0; ID_EX_MemRead = 1; ID_EX_RegWrite = 1;
        exp_run("dest0", 0, 0, 0, 2'b00, 2'b00);

        next(); ID_IsBranch = 1; ID_Rs = 3; ID_UsesRs = 1; ID_EX_Dest = 3; ID_EX_RegWrite = 1;
        exp_stall("rs_s1");
        next(); ID_IsBranch = 1; ID_Rs = 3; ID_UsesRs = 1; ID_EX_Dest = 3; ID_EX_RegWrite = 1;
        rst = 1'b1;
        exp_stall("rs_s2");
        next(); rst = 1'b0;
        exp_run("rs_after", 0, 0, 0, 2'b00, 2'b00);

        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
